// File: rtl/vga_timing_defs.sv
// Shared 640x480@60 defaults, pixel-fetch latency bounds and the line-segment
// decode used by the VGA timing generator.
package vga_timing_defs;

    localparam int unsigned DEF_H_ACT   = 640;
    localparam int unsigned DEF_H_FRONT = 16;
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_V_ACT   = 480;
    localparam int unsigned DEF_V_FRONT = 10;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_COLOR_W = 4;
    localparam int unsigned DEF_LATENCY = 2;
    localparam int unsigned DEF_CW      = 11;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 8;

    // A line (or frame) is front porch, sync, back porch, then active.
    typedef enum logic [1:0] {
        SegFront,
        SegSync,
        SegBack,
        SegAct
    } seg_e;

    function automatic seg_e seg_of(input int unsigned pos, input int unsigned front,
                                    input int unsigned sync, input int unsigned back);
        seg_e seg;
        if (pos < front) begin
            seg = SegFront;
        end else if (pos < front + sync) begin
            seg = SegSync;
        end else if (pos < front + sync + back) begin
            seg = SegBack;
        end else begin
            seg = SegAct;
        end
        return seg;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Host pixel-fetch port: the generator requests a pixel by coordinate and the
// host returns its colour a fixed number of enabled cycles later.
interface vga_timing_gen_if
    import vga_timing_defs::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned COLOR_W = DEF_COLOR_W
);
    logic               oReq;
    logic [CW-1:0]      oCurrent_X;
    logic [CW-1:0]      oCurrent_Y;
    logic               oFrame_Start;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;

    modport master (
        output oReq, oCurrent_X, oCurrent_Y, oFrame_Start,
        input  iRed, iGreen, iBlue
    );

    modport slave (
        input  oReq, oCurrent_X, oCurrent_Y, oFrame_Start,
        output iRed, iGreen, iBlue
    );
endinterface

// File: rtl/vga_tdelay.sv
// Clock-enabled shift register: o_data is i_data delayed by DEPTH enabled cycles.
module vga_tdelay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_ce) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel requests decoded straight from the counters, with
// syncs and display enable delayed to line up with the host's returned colour.
module vga_timing_gen
    import vga_timing_defs::*;
#(
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FRONT = DEF_V_FRONT,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned COLOR_W = DEF_COLOR_W,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCE,
    vga_timing_gen_if.master   host,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_DE
);
    localparam int unsigned H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACT;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACT;

    localparam logic [CW-1:0] H_BLANK_C = CW'(H_BLANK);
    localparam logic [CW-1:0] V_BLANK_C = CW'(V_BLANK);
    localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("vga_timing_gen: LATENCY must be within 1..8");
    end
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for the configured totals");
    end

    logic [CW-1:0] r_h_cont;
    logic [CW-1:0] r_v_cont;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h_cont == H_LAST_C);
    assign w_v_last = (r_v_cont == V_LAST_C);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_h_cont <= '0;
            r_v_cont <= '0;
        end else if (iCE) begin
            if (w_h_last) begin
                r_h_cont <= '0;
                r_v_cont <= w_v_last ? '0 : r_v_cont + CW'(1);
            end else begin
                r_h_cont <= r_h_cont + CW'(1);
            end
        end
    end

    seg_e w_h_seg;
    seg_e w_v_seg;
    logic w_active;

    assign w_h_seg  = seg_of(32'(r_h_cont), H_FRONT, H_SYNC, H_BACK);
    assign w_v_seg  = seg_of(32'(r_v_cont), V_FRONT, V_SYNC, V_BACK);
    assign w_active = (w_h_seg == SegAct) && (w_v_seg == SegAct);

    assign host.oReq         = w_active;
    assign host.oCurrent_X   = w_active ? r_h_cont - H_BLANK_C : '0;
    assign host.oCurrent_Y   = w_active ? r_v_cont - V_BLANK_C : '0;
    assign host.oFrame_Start = w_active && (r_h_cont == H_BLANK_C) && (r_v_cont == V_BLANK_C);

    // Bit order: {hs, vs, de}, all active-high before polarity is applied.
    logic [2:0] w_raw;
    logic [2:0] w_dly;

    assign w_raw = {w_h_seg == SegSync, w_v_seg == SegSync, w_active};

    vga_tdelay #(
        .WIDTH(3),
        .DEPTH(LATENCY)
    ) u_tdelay (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_ce  (iCE),
        .i_data(w_raw),
        .o_data(w_dly)
    );

    assign oVGA_HS = w_dly[2] ? HS_POL : ~HS_POL;
    assign oVGA_VS = w_dly[1] ? VS_POL : ~VS_POL;
    assign oVGA_DE = w_dly[0];
    assign oVGA_R  = w_dly[0] ? host.iRed   : '0;
    assign oVGA_G  = w_dly[0] ? host.iGreen : '0;
    assign oVGA_B  = w_dly[0] ? host.iBlue  : '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a 640x480 default instance and a tiny-timing instance, both
// checked cycle by cycle against an arithmetic model of enabled-cycle count.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        req;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] xd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst, d_ce, t_rst, t_ce;
    logic [3:0] d_r, d_g, d_b, t_r, t_g, t_b;
    logic d_hs, d_vs, d_de, t_hs, t_vs, t_de;

    vga_timing_gen_if #(.CW(11), .COLOR_W(4)) d_if ();
    vga_timing_gen_if #(.CW(4),  .COLOR_W(4)) t_if ();

    vga_timing_gen #(
        .LATENCY(2)
    ) u_def (
        .iCLK   (clk),
        .iRST   (d_rst),
        .iCE    (d_ce),
        .host   (d_if),
        .oVGA_R (d_r),
        .oVGA_G (d_g),
        .oVGA_B (d_b),
        .oVGA_HS(d_hs),
        .oVGA_VS(d_vs),
        .oVGA_DE(d_de)
    );

    vga_timing_gen #(
        .H_ACT(4), .H_FRONT(2), .H_SYNC(1), .H_BACK(1),
        .V_ACT(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(1), .CW(4)
    ) u_tiny (
        .iCLK   (clk),
        .iRST   (t_rst),
        .iCE    (t_ce),
        .host   (t_if),
        .oVGA_R (t_r),
        .oVGA_G (t_g),
        .oVGA_B (t_b),
        .oVGA_HS(t_hs),
        .oVGA_VS(t_vs),
        .oVGA_DE(t_de)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int n, input int lat, input int hfp, input int hsy,
                                   input int hbl, input int htot, input int vfp, input int vsy,
                                   input int vbl, input int vtot);
        exp_t e;
        int h, v, k;
        e = '0;
        h = n % htot;
        v = (n / htot) % vtot;
        e.req = (h >= hbl) && (v >= vbl);
        if (e.req) begin
            e.x = 16'(h - hbl);
            e.y = 16'(v - vbl);
        end
        e.fs = e.req && (h == hbl) && (v == vbl);
        k = n - lat;
        if (k >= 0) begin
            h = k % htot;
            v = (k / htot) % vtot;
            e.hs = (h >= hfp) && (h < hfp + hsy);
            e.vs = (v >= vfp) && (v < vfp + vsy);
            e.de = (h >= hbl) && (v >= vbl);
            if (e.de) e.xd = 16'(h - hbl);
        end
        return e;
    endfunction

    // Host models and bookkeeping
    logic [3:0] d_hist [2];
    logic [3:0] t_hist;
    logic [3:0] d_pend, t_pend;
    bit   act_d, act_t, prev_ce;
    int   n_d, n_t, cyc, phase;
    int   err_d, err_t, err_hold;
    logic [38:0] prev_snap;
    logic prev_hs;
    int   falls[$];
    int   hs_low0, vs_low, de_line, req_line, d_fs_cnt;
    int   t_fs_cnt, t_fs0, t_fs1, t_req_f0, t_vs_f0;

    task automatic drive_hosts();
        d_if.iRed   = d_hist[1];
        d_if.iGreen = d_hist[1] ^ 4'h5;
        d_if.iBlue  = 4'hA;
        t_if.iRed   = t_hist;
        t_if.iGreen = t_hist ^ 4'h5;
        t_if.iBlue  = 4'hA;
    endtask

    task automatic sample();
        exp_t e;
        logic [38:0] snap;
        if (act_d) begin
            e = model(n_d, 2, 16, 96, 160, 800, 10, 2, 45, 525);
            if (d_if.oReq !== e.req || d_if.oCurrent_X !== 11'(e.x)
                || d_if.oCurrent_Y !== 11'(e.y) || d_if.oFrame_Start !== e.fs
                || d_hs !== ~e.hs || d_vs !== ~e.vs || d_de !== e.de
                || d_r !== (e.de ? 4'(e.xd) : 4'h0)
                || d_g !== (e.de ? (4'(e.xd) ^ 4'h5) : 4'h0)
                || d_b !== (e.de ? 4'hA : 4'h0)) err_d++;
            snap = {d_if.oReq, d_if.oFrame_Start, d_if.oCurrent_X, d_if.oCurrent_Y,
                    d_r, d_g, d_b, d_hs, d_vs, d_de};
            if (!prev_ce && snap !== prev_snap) err_hold++;
            prev_snap = snap;
            if (prev_hs === 1'b1 && d_hs === 1'b0) falls.push_back(cyc);
            prev_hs = d_hs;
            d_pend = d_if.oReq ? d_if.oCurrent_X[3:0] : 4'hF;
            if (phase == 1) begin
                if (n_d < 800 && d_hs === 1'b0) hs_low0++;
                if (d_vs === 1'b0) vs_low++;
                if (n_d >= 36002 && n_d < 36802 && d_de === 1'b1) de_line++;
                if (n_d >= 36000 && n_d < 36800 && d_if.oReq === 1'b1) req_line++;
                if (d_if.oFrame_Start === 1'b1) d_fs_cnt++;
                if (n_d == 36160) begin
                    check_eq("first_px_req", d_if.oReq, 1);
                    check_eq("first_px_x", d_if.oCurrent_X, 0);
                    check_eq("first_px_fs", d_if.oFrame_Start, 1);
                end
                if (n_d == 36799) check_eq("last_px_x", d_if.oCurrent_X, 639);
                if (n_d == 36800) check_eq("after_line_req", d_if.oReq, 0);
            end
        end
        if (act_t) begin
            e = model(n_t, 1, 2, 1, 4, 8, 1, 1, 3, 5);
            if (t_if.oReq !== e.req || t_if.oCurrent_X !== 4'(e.x)
                || t_if.oCurrent_Y !== 4'(e.y) || t_if.oFrame_Start !== e.fs
                || t_hs !== e.hs || t_vs !== e.vs || t_de !== e.de
                || t_r !== (e.de ? 4'(e.xd) : 4'h0)
                || t_g !== (e.de ? (4'(e.xd) ^ 4'h5) : 4'h0)
                || t_b !== (e.de ? 4'hA : 4'h0)) err_t++;
            t_pend = t_if.oReq ? t_if.oCurrent_X : 4'hF;
            if (phase == 1) begin
                if (t_if.oFrame_Start === 1'b1) begin
                    t_fs_cnt++;
                    if (t_fs_cnt == 1) t_fs0 = n_t;
                    if (t_fs_cnt == 2) t_fs1 = n_t;
                end
                if (n_t < 40 && t_if.oReq === 1'b1) t_req_f0++;
                if (n_t >= 1 && n_t < 41 && t_vs === 1'b1) t_vs_f0++;
            end
        end
    endtask

    task automatic run_cycles(input int cycles, input bit half_ce);
        for (int c = 0; c < cycles; c++) begin
            logic ce_now;
            ce_now = half_ce ? (c % 2 == 0) : 1'b1;
            d_ce = ce_now;
            t_ce = ce_now;
            #1;
            sample();
            cyc++;
            @(posedge clk);
            #1;
            if (ce_now) begin
                if (act_d) begin
                    n_d++;
                    d_hist[1] = d_hist[0];
                    d_hist[0] = d_pend;
                end
                if (act_t) begin
                    n_t++;
                    t_hist = t_pend;
                end
                drive_hosts();
            end
            prev_ce = ce_now;
        end
    endtask

    task automatic release_def();
        d_rst = 1'b0; act_d = 1'b1; n_d = 0; cyc = 0; prev_ce = 1'b1; prev_hs = 1'b1;
        d_hist[0] = 4'h0; d_hist[1] = 4'h0; falls.delete();
        drive_hosts();
    endtask

    task automatic release_tiny();
        t_rst = 1'b0; act_t = 1'b1; n_t = 0; t_hist = 4'h0;
        drive_hosts();
    endtask

    initial begin
        d_rst = 1'b1; t_rst = 1'b1; d_ce = 1'b1; t_ce = 1'b1;
        act_d = 1'b0; act_t = 1'b0; phase = 0;
        err_d = 0; err_t = 0; err_hold = 0; hs_low0 = 0; vs_low = 0; de_line = 0;
        req_line = 0; d_fs_cnt = 0; t_fs_cnt = 0; t_fs0 = -1; t_fs1 = -1;
        t_req_f0 = 0; t_vs_f0 = 0; prev_snap = '0;
        d_hist[0] = 4'hF; d_hist[1] = 4'hF; t_hist = 4'hF;
        drive_hosts();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_def_hs", d_hs, 1);
        check_eq("rst_def_vs", d_vs, 1);
        check_eq("rst_def_de", d_de, 0);
        check_eq("rst_def_r", d_r, 0);
        check_eq("rst_def_req", d_if.oReq, 0);
        check_eq("rst_tiny_hs", t_hs, 0);
        check_eq("rst_tiny_vs", t_vs, 0);

        // Phase 1: continuous enable, both instances
        release_def();
        release_tiny();
        phase = 1;
        run_cycles(37000, 1'b0);
        check_eq("hs_fall_count", falls.size(), 47);
        check_eq("hs_first_fall", (falls.size() > 0) ? falls[0] : -1, 18);
        check_eq("line_period", (falls.size() > 1) ? falls[1] - falls[0] : -1, 800);
        check_eq("hs_low_width", hs_low0, 96);
        check_eq("vs_low_width", vs_low, 1600);
        check_eq("de_per_line", de_line, 640);
        check_eq("req_per_line", req_line, 640);
        check_eq("def_fs_count", d_fs_cnt, 1);
        check_eq("tiny_fs_first", t_fs0, 28);
        check_eq("tiny_fs_period", t_fs1 - t_fs0, 40);
        check_eq("tiny_fs_count", t_fs_cnt, 925);
        check_eq("tiny_req_frame", t_req_f0, 8);
        check_eq("tiny_vs_frame", t_vs_f0, 8);

        // Phase 2: mid-frame reset, then 50% clock enable
        #1;
        check_eq("pre_rst_def_de", d_de, 1);
        d_rst = 1'b1; t_rst = 1'b1; act_d = 1'b0; act_t = 1'b0;
        #1;
        check_eq("async_rst_def_de", d_de, 0);
        check_eq("async_rst_def_r", d_r, 0);
        check_eq("async_rst_def_hs", d_hs, 1);
        release_def();
        phase = 2;
        run_cycles(1700, 1'b1);
        check_eq("half_ce_first_fall", (falls.size() > 0) ? falls[0] : -1, 35);
        check_eq("half_ce_period", (falls.size() > 1) ? falls[1] - falls[0] : -1, 1600);
        check_eq("hold_on_ce_low", err_hold, 0);

        // Phase 3: tiny instance, asynchronous reset with positive-polarity syncs
        d_rst = 1'b1; act_d = 1'b0;
        phase = 3;
        release_tiny();
        run_cycles(30, 1'b0);
        #1;
        check_eq("pre_rst_tiny_de", t_de, 1);
        check_eq("pre_rst_tiny_r", t_r, 1);
        t_rst = 1'b1; act_t = 1'b0;
        #1;
        check_eq("async_rst_tiny_de", t_de, 0);
        check_eq("async_rst_tiny_r", t_r, 0);
        check_eq("async_rst_tiny_req", t_if.oReq, 0);
        release_tiny();
        run_cycles(11, 1'b0);
        #1;
        check_eq("pre_rst_tiny_hs", t_hs, 1);
        check_eq("pre_rst_tiny_vs", t_vs, 1);
        t_rst = 1'b1; act_t = 1'b0;
        #1;
        check_eq("async_rst_tiny_hs", t_hs, 0);
        check_eq("async_rst_tiny_vs", t_vs, 0);
        release_tiny();
        run_cycles(45, 1'b0);

        check_eq("def_cycle_model", err_d, 0);
        check_eq("tiny_cycle_model", err_t, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
